mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Arbiter and sequencer for the pipeline's single-port memory. The fetch stage and the load/store path both use this memory. The block accepts read requests from fetch and read/write requests from the data path. It grants one requester at a time and drives the memory port. It returns read data with a fixed-latency handshake. Data accesses have priority, and a starvation guard guarantees that fetch eventually makes progress.

## Interface
- `AW`, 32, address width (byte address, passed through unchanged)
- `DW`, 32, data width
- `MEM_LAT`, 2, cycles from the `mem_en` cycle to valid `mem_rdata`; legal range 1..15
- `STARVE_LIMIT`, 4, maximum consecutive data grants while a fetch request waits; legal range 1..15

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge
- `reset`  in  1  asynchronous, active-high reset
- `if_req`  in  1  fetch read request; held with `if_addr` stable until `if_gnt`
- `if_addr`  in  AW  fetch address
- `if_gnt`  out  1  fetch request accepted this cycle
- `if_rvalid`  out  1  one-cycle pulse: `if_rdata` valid
- `if_rdata`  out  DW  fetch read data; held until the next `if_rvalid`
- `dm_req`  in  1  data request; held with its payload stable until `dm_gnt`
- `dm_we`  in  1  1 = write, 0 = read
- `dm_addr`  in  AW  data address
- `dm_wdata`  in  DW  write data
- `dm_gnt`  out  1  data request accepted this cycle
- `dm_rvalid`  out  1  one-cycle pulse: `dm_rdata` valid; reads only
- `dm_rdata`  out  DW  data read data; held until the next `dm_rvalid`
- `mem_en`  out  1  memory access strobe
- `mem_we`  out  1  memory write enable; qualified by `mem_en`
- `mem_addr`  out  AW  memory address
- `mem_wdata`  out  DW  memory write data
- `mem_rdata`  in  DW  memory read data, valid `MEM_LAT` cycles after `mem_en`
- `busy`  out  1  a transaction is in progress (state is not IDLE)

## Operation
- States:
  - **IDLE**: no transaction in flight.
  - **ISSUE**: the memory strobe is driven for exactly one cycle.
  - **WAIT**: a read is counting down the memory latency.
  - **RESP**: the read data is captured.
- In IDLE, when `if_req` or `dm_req` is high:
  - Exactly one grant is asserted combinationally in that cycle.
  - The winner's address, write data, write enable and owner are latched at the clock edge.
  - The state moves to ISSUE.
- Grants are never asserted outside IDLE. Requests that arrive while busy wait with no grant.
- Arbitration rule:
  - `dm_req` wins unless `if_req` is high and `streak` == `STARVE_LIMIT`; in that case fetch wins.
  - `streak` increments on a data grant when `if_req` is high.
  - `streak` clears on a data grant when `if_req` is low.
  - `streak` clears on any fetch grant.
  - `streak` saturates at `STARVE_LIMIT`.
- ISSUE:
  - `mem_en`=1; `mem_addr`, `mem_wdata` and `mem_we` come from the latched registers.
  - Write: the next state is IDLE. No rvalid is generated.
  - Read: the latency counter loads `MEM_LAT`-1. The next state is WAIT, or RESP if `MEM_LAT`==1.
- WAIT: the counter decrements each cycle. At 0 the next state is RESP.
- RESP:
  - `mem_rdata` is sampled into the owner's rdata register.
  - The owner's rvalid is set for the next cycle.
  - The next state is IDLE.
- Fetch is read-only; `mem_we` is always 0 for fetch transactions.
- Memory outputs are registered. When `mem_en`=0, `mem_we` is 0 and `mem_addr`/`mem_wdata` hold their last values.
- Reset: all of the following are 0 asynchronously:
  - state = IDLE
  - `streak` and the latency counter
  - `mem_en`, `mem_we`, `mem_addr`, `mem_wdata`
  - both rvalid and both rdata outputs
  - `busy`
- Reset mid-transaction abandons the access. No rvalid is produced afterwards. `mem_en` drops immediately.

## Timing
- Grant in cycle 0. Then:
  - `mem_en` in cycle 1.
  - `mem_rdata` sampled at the end of cycle 1+`MEM_LAT`.
  - rvalid high in cycle 2+`MEM_LAT`.
- The rvalid cycle is also the IDLE cycle, so a new grant may coincide with an rvalid pulse.
- Read occupancy: the next grant is possible no earlier than cycle `MEM_LAT`+2.
- Write occupancy: the next grant is possible in cycle 2.
- Back-to-back reads at `MEM_LAT`=2: grants in cycles 0, 4, 8, …
- `if_gnt` and `dm_gnt` are never high together. At most one of `if_rvalid`/`dm_rvalid` is high in any cycle.
- A request dropped before its grant is legal and causes no side effect.

## Test plan
- **Reset:**
  - Assert `reset` while `mem_en`=1 → all outputs are 0 in the same cycle.
  - Release `reset` → state IDLE; no rvalid ever appears for the abandoned access.
- **Single fetch read,** `MEM_LAT`=2, `if_addr`=0x10, memory returns 0xDEADBEEF:
  - `if_gnt` in cycle 0; `mem_en`=1 with `mem_addr`=0x10 in cycle 1.
  - `if_rvalid`=1 with `if_rdata`=0xDEADBEEF in cycle 4; `busy`=0 in cycle 4.
- **Data write,** `dm_addr`=0x8, `dm_wdata`=0x1234, `dm_we`=1:
  - `mem_en`=`mem_we`=1 in cycle 1 with those values.
  - No `dm_rvalid`.
  - A pending fetch is granted in cycle 2.
- **Simultaneous requests:**
  - `if_req` and `dm_req` both high with `streak`=0 → `dm_gnt` only; `if_gnt` follows at the next IDLE.
- **Starvation guard,** `STARVE_LIMIT`=4:
  - `dm_req` and `if_req` held continuously with data writes → 4 consecutive `dm_gnt`, then `if_gnt`, then `dm_gnt` again.
- **`MEM_LAT`=1 back-to-back data reads:**
  - Grants in cycles 0 and 3.
  - `dm_rvalid` in cycles 3 and 6, each carrying the correct `mem_rdata`.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Arbitrates the single-port memory between the fetch stage (read-only)
//   and the load/store path (read/write). One transaction is in flight at a
//   time: IDLE -> ISSUE -> [WAIT] -> RESP -> IDLE for reads, IDLE -> ISSUE ->
//   IDLE for writes. Data accesses win arbitration, except that after
//   STARVE_LIMIT consecutive data grants with fetch waiting, fetch wins once.
//
// Ports
//   clk, reset            clock, asynchronous active-high reset
//   if_req/if_addr        fetch read request (held until if_gnt)
//   if_gnt                fetch accepted (combinational, IDLE only)
//   if_rvalid/if_rdata    fetch read return; rdata held between pulses
//   dm_req/dm_we/dm_addr/dm_wdata  data request (held until dm_gnt)
//   dm_gnt                data accepted (combinational, IDLE only)
//   dm_rvalid/dm_rdata    data read return; rdata held between pulses
//   mem_en/mem_we/mem_addr/mem_wdata  registered memory port
//   mem_rdata             memory read data, valid MEM_LAT cycles after mem_en
//   busy                  a transaction is in progress
module mem_port_arbiter #(
    parameter int AW           = 32,
    parameter int DW           = 32,
    parameter int MEM_LAT      = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_rvalid,
    output logic [DW-1:0] if_rdata,
    input  logic          dm_req,
    input  logic          dm_we,
    input  logic [AW-1:0] dm_addr,
    input  logic [DW-1:0] dm_wdata,
    output logic          dm_gnt,
    output logic          dm_rvalid,
    output logic [DW-1:0] dm_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

    localparam logic [3:0] LAT_LD = 4'(MEM_LAT - 1);
    localparam logic [3:0] SLIM   = 4'(STARVE_LIMIT);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t     state, state_nxt;
    logic [3:0] streak;     // consecutive data grants while fetch waited
    logic [3:0] lat_cnt;    // remaining memory latency cycles
    logic       owner_dm;   // 1: current transaction belongs to the data path
    logic       fetch_wins;

    // Fetch wins if data is not asking, or if fetch has been starved long enough.
    always_comb begin
        fetch_wins = if_req && (!dm_req || (streak == SLIM));
        if_gnt     = (state == IDLE) && fetch_wins;
        dm_gnt     = (state == IDLE) && dm_req && !fetch_wins;
        busy       = (state != IDLE);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (if_req || dm_req) state_nxt = ISSUE;
            // mem_we is the latched write flag of the transaction being issued
            ISSUE: begin
                if (mem_we)            state_nxt = IDLE;
                else if (MEM_LAT == 1) state_nxt = RESP;
                else                   state_nxt = WAIT;
            end
            // counter reaches 0 on this edge -> data is valid during RESP
            WAIT:  if (lat_cnt == 4'd1) state_nxt = RESP;
            RESP:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            streak    <= '0;
            lat_cnt   <= '0;
            owner_dm  <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_rvalid <= 1'b0;
            dm_rvalid <= 1'b0;
            if_rdata  <= '0;
            dm_rdata  <= '0;
        end else begin
            state     <= state_nxt;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            if_rvalid <= 1'b0;
            dm_rvalid <= 1'b0;

            if (if_gnt) begin
                mem_en   <= 1'b1;
                mem_addr <= if_addr;
                owner_dm <= 1'b0;
                streak   <= '0;
            end else if (dm_gnt) begin
                mem_en    <= 1'b1;
                mem_we    <= dm_we;
                mem_addr  <= dm_addr;
                mem_wdata <= dm_wdata;
                owner_dm  <= 1'b1;
                if (!if_req)              streak <= '0;
                else if (streak != SLIM)  streak <= streak + 4'd1;
            end

            case (state)
                ISSUE: if (!mem_we) lat_cnt <= LAT_LD;
                WAIT:  lat_cnt <= lat_cnt - 4'd1;
                RESP: begin
                    if (owner_dm) begin
                        dm_rdata  <= mem_rdata;
                        dm_rvalid <= 1'b1;
                    end else begin
                        if_rdata  <= mem_rdata;
                        if_rvalid <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;

    // DUT with MEM_LAT = 2
    logic        if_req, if_gnt, if_rvalid;
    logic [31:0] if_addr, if_rdata;
    logic        dm_req, dm_we, dm_gnt, dm_rvalid;
    logic [31:0] dm_addr, dm_wdata, dm_rdata;
    logic        mem_en, mem_we, busy;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    // DUT with MEM_LAT = 1
    logic        if_req1, if_gnt1, if_rvalid1;
    logic [31:0] if_addr1, if_rdata1;
    logic        dm_req1, dm_we1, dm_gnt1, dm_rvalid1;
    logic [31:0] dm_addr1, dm_wdata1, dm_rdata1;
    logic        mem_en1, mem_we1, busy1;
    logic [31:0] mem_addr1, mem_wdata1, mem_rdata1;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(2), .STARVE_LIMIT(4)) u_dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
    );

    mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(1), .STARVE_LIMIT(4)) u_dut1 (
        .clk(clk), .reset(reset),
        .if_req(if_req1), .if_addr(if_addr1), .if_gnt(if_gnt1),
        .if_rvalid(if_rvalid1), .if_rdata(if_rdata1),
        .dm_req(dm_req1), .dm_we(dm_we1), .dm_addr(dm_addr1), .dm_wdata(dm_wdata1),
        .dm_gnt(dm_gnt1), .dm_rvalid(dm_rvalid1), .dm_rdata(dm_rdata1),
        .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1),
        .mem_wdata(mem_wdata1), .mem_rdata(mem_rdata1), .busy(busy1)
    );

    function automatic logic [31:0] mem_val(input logic [31:0] a);
        return (a == 32'h10) ? 32'hDEADBEEF : (a ^ 32'hA5A50000);
    endfunction

    // Memory models: data valid only in the one cycle MEM_LAT after mem_en.
    logic        pv [0:15];
    logic [31:0] pa [0:15];
    initial for (int k = 0; k < 16; k++) begin pv[k] = 1'b0; pa[k] = '0; end

    always @(posedge clk) begin
        for (int k = 15; k > 0; k--) begin pv[k] = pv[k-1]; pa[k] = pa[k-1]; end
        pv[0] = mem_en;
        pa[0] = mem_addr;
        mem_rdata <= pv[1] ? mem_val(pa[1]) : 32'hBAD0BAD0;
    end

    always @(posedge clk)
        mem_rdata1 <= mem_en1 ? mem_val(mem_addr1) : 32'hBAD0BAD0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    task automatic next_cyc();
        @(negedge clk);
    endtask

    logic [5:0] gseq;
    int         ng;
    logic       both_gnt, rv_seen;

    initial begin
        reset   = 1'b1;
        if_req  = 0; if_addr  = 0; dm_req  = 0; dm_we  = 0; dm_addr  = 0; dm_wdata  = 0;
        if_req1 = 0; if_addr1 = 0; dm_req1 = 0; dm_we1 = 0; dm_addr1 = 0; dm_wdata1 = 0;

        // reset state
        next_cyc(); #1;
        chk("reset_outs", {if_gnt, dm_gnt, if_rvalid, dm_rvalid, mem_en, mem_we, busy,
                           mem_addr, mem_wdata}, '0);
        chk("reset_rdata", {if_rdata, dm_rdata}, '0);
        reset = 1'b0;

        // single fetch read, addr 0x10
        next_cyc(); if_req = 1; if_addr = 32'h10; #1;
        chk("f_gnt", {if_gnt, dm_gnt, busy}, 3'b100);
        next_cyc(); if_req = 0; #1;
        chk("f_issue", {mem_en, mem_we, busy, mem_addr}, {3'b101, 32'h10});
        next_cyc(); #1;
        chk("f_en_pulse", mem_en, 1'b0);
        next_cyc(); #1;
        chk("f_no_early_rv", if_rvalid, 1'b0);
        next_cyc(); #1;
        chk("f_rvalid", {if_rvalid, dm_rvalid, busy, if_rdata}, {3'b100, 32'hDEADBEEF});
        next_cyc(); #1;
        chk("f_rdata_hold", {if_rvalid, if_rdata}, {1'b0, 32'hDEADBEEF});

        // data write with a simultaneous fetch request
        next_cyc(); dm_req = 1; dm_we = 1; dm_addr = 32'h8; dm_wdata = 32'h1234;
        if_req = 1; if_addr = 32'h20; #1;
        chk("sim_gnt", {dm_gnt, if_gnt}, 2'b10);
        next_cyc(); dm_req = 0; #1;
        chk("w_issue", {mem_en, mem_we, if_gnt, mem_addr, mem_wdata[15:0]},
            {3'b110, 32'h8, 16'h1234});
        next_cyc(); #1;
        chk("w_fetch_gnt", {if_gnt, dm_gnt, dm_rvalid, mem_en}, 4'b1000);
        next_cyc(); if_req = 0; #1;
        chk("w_no_dm_rv", {dm_rvalid, mem_addr}, {1'b0, 32'h20});
        next_cyc(); next_cyc(); next_cyc(); #1;
        chk("f2_rvalid", {if_rvalid, dm_rvalid, if_rdata}, {2'b10, mem_val(32'h20)});

        // starvation guard: both held, data writes
        next_cyc(); dm_req = 1; dm_we = 1; dm_addr = 32'h30; if_req = 1;
        gseq = '0; ng = 0; both_gnt = 0;
        for (int c = 0; c < 40 && ng < 6; c++) begin
            #1;
            if (if_gnt && dm_gnt) both_gnt = 1;
            if (if_gnt || dm_gnt) begin gseq[ng] = if_gnt; ng++; end
            if (ng < 6) next_cyc();
        end
        dm_req = 0; if_req = 0;
        chk("starve_count", 32'(ng), 32'd6);
        chk("starve_seq", gseq, 6'b010000);
        chk("starve_excl", both_gnt, 1'b0);
        repeat (6) next_cyc();

        // reset in the middle of a data read
        next_cyc(); dm_req = 1; dm_we = 0; dm_addr = 32'h40; #1;
        chk("rr_gnt", dm_gnt, 1'b1);
        next_cyc(); dm_req = 0; #1;
        chk("rr_issue", {mem_en, mem_addr}, {1'b1, 32'h40});
        #1 reset = 1'b1; #1;
        chk("rr_async", {mem_en, mem_we, busy, dm_rvalid, if_rvalid, mem_addr, mem_wdata}, '0);
        next_cyc(); reset = 1'b0;
        rv_seen = 0;
        for (int c = 0; c < 6; c++) begin
            #1; if (dm_rvalid || if_rvalid || busy) rv_seen = 1;
            next_cyc();
        end
        chk("rr_no_rv", rv_seen, 1'b0);

        // MEM_LAT = 1 back-to-back data reads
        dm_req1 = 1; dm_we1 = 0; dm_addr1 = 32'h100; #1;
        chk("l1_g0", dm_gnt1, 1'b1);
        next_cyc(); dm_addr1 = 32'h104; #1;
        chk("l1_c1", {dm_gnt1, mem_en1, mem_addr1}, {2'b01, 32'h100});
        next_cyc(); #1;
        chk("l1_c2", {dm_gnt1, dm_rvalid1}, 2'b00);
        next_cyc(); #1;
        chk("l1_c3", {dm_gnt1, dm_rvalid1, dm_rdata1}, {2'b11, mem_val(32'h100)});
        next_cyc(); dm_req1 = 0; #1;
        chk("l1_c4", {dm_rvalid1, mem_en1, mem_addr1}, {2'b01, 32'h104});
        next_cyc(); next_cyc(); #1;
        chk("l1_c6", {dm_rvalid1, dm_rdata1, busy1}, {1'b1, mem_val(32'h104), 1'b0});

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
